// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port, the stall input and
// the if_id word handed to decode.
interface instr_fetch_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  stall;
  logic [ADDR_WIDTH-1:0] imem_address;
  logic                  imem_read_enable;
  logic [31:0]           imem_data;
  logic [31:0]           if_id_reg;
  logic                  if_id_valid;
  logic [ADDR_WIDTH-1:0] if_id_pc;
  logic                  halted;

  modport master (
    input  stall,
    input  imem_data,
    output imem_address,
    output imem_read_enable,
    output if_id_reg,
    output if_id_valid,
    output if_id_pc,
    output halted
  );

  modport slave (
    output stall,
    output imem_data,
    input  imem_address,
    input  imem_read_enable,
    input  if_id_reg,
    input  if_id_valid,
    input  if_id_pc,
    input  halted
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage. Walks a PC through a synchronous-read instruction
// memory and hands one word per cycle to decode. A single-entry skid buffer
// catches the word that returns while stall is high, so nothing is lost or
// repeated. Fetch stops at PROGRAM_DEPTH and raises halted once drained.
module instr_fetch #(
  parameter int ADDR_WIDTH    = 8,
  parameter int PROGRAM_DEPTH = 256
) (
  input logic           clock,
  input logic           reset,
  instr_fetch_if.master fetch
);

  // pc is one bit wider than the address so it can sit at PROGRAM_DEPTH.
  localparam logic [ADDR_WIDTH:0] PC_END = (ADDR_WIDTH + 1)'(PROGRAM_DEPTH);

  logic                  stall;
  logic [ADDR_WIDTH:0]   pc;
  logic                  read_enable;
  logic                  inflight;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic                  skid_valid;
  logic [31:0]           skid_data;
  logic [ADDR_WIDTH-1:0] skid_pc;
  logic [31:0]           if_id_reg;
  logic                  if_id_valid;
  logic [ADDR_WIDTH-1:0] if_id_pc;
  logic                  halted;

  assign stall       = fetch.stall;
  // No read is launched during stall, which is what bounds the skid to one entry.
  assign read_enable = !reset && !stall && (pc < PC_END);

  assign fetch.imem_address     = pc[ADDR_WIDTH-1:0];
  assign fetch.imem_read_enable = read_enable;
  assign fetch.if_id_reg        = if_id_reg;
  assign fetch.if_id_valid      = if_id_valid;
  assign fetch.if_id_pc         = if_id_pc;
  assign fetch.halted           = halted;

  // Control state and the decode-facing register: issue, deliver, halt.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc          <= '0;
      inflight    <= 1'b0;
      skid_valid  <= 1'b0;
      if_id_reg   <= '0;
      if_id_valid <= 1'b0;
      if_id_pc    <= '0;
      halted      <= 1'b0;
    end else begin
      if (read_enable) begin
        pc       <= pc + 1'b1;
        inflight <= 1'b1;
      end else begin
        inflight <= 1'b0;
      end

      if (stall) begin
        // Decode is frozen; park a returning word, otherwise hold everything.
        if (inflight) skid_valid <= 1'b1;
      end else if (skid_valid) begin
        // The parked word is older than anything now in flight, so it goes first.
        if_id_reg   <= skid_data;
        if_id_pc    <= skid_pc;
        if_id_valid <= 1'b1;
        skid_valid  <= 1'b0;
      end else if (inflight) begin
        if_id_reg   <= fetch.imem_data;
        if_id_pc    <= inflight_pc;
        if_id_valid <= 1'b1;
      end else begin
        if_id_reg   <= '0;
        if_id_valid <= 1'b0;
        if_id_pc    <= '0;
      end

      // With pc at the end and nothing in flight or parked, the last word has left.
      if (pc == PC_END && !inflight && !skid_valid) halted <= 1'b1;
    end
  end

  // Data-only tracking of the in-flight address and the parked word.
  always_ff @(posedge clock) begin
    if (read_enable) inflight_pc <= pc[ADDR_WIDTH-1:0];
    if (stall && inflight) begin
      skid_data <= fetch.imem_data;
      skid_pc   <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: three instances (depth 4, 8 and 1) sharing clock,
// reset and stall, each behind its own synchronous-read memory model.
module tb_instr_fetch;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic stall = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [39:0] exp_q[$];

  instr_fetch_if #(.ADDR_WIDTH(8)) if4 ();
  instr_fetch_if #(.ADDR_WIDTH(8)) if8 ();
  instr_fetch_if #(.ADDR_WIDTH(8)) if1 ();

  assign if4.stall = stall;
  assign if8.stall = stall;
  assign if1.stall = stall;

  instr_fetch #(.ADDR_WIDTH(8), .PROGRAM_DEPTH(4)) dut4 (.clock(clock), .reset(reset), .fetch(if4));
  instr_fetch #(.ADDR_WIDTH(8), .PROGRAM_DEPTH(8)) dut8 (.clock(clock), .reset(reset), .fetch(if8));
  instr_fetch #(.ADDR_WIDTH(8), .PROGRAM_DEPTH(1)) dut1 (.clock(clock), .reset(reset), .fetch(if1));

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input int a);
    return 32'h2000_0000 + a;
  endfunction

  always @(posedge clock) if (if4.imem_read_enable) if4.imem_data <= mem_word(int'(if4.imem_address));
  always @(posedge clock) if (if8.imem_read_enable) if8.imem_data <= mem_word(int'(if8.imem_address));
  always @(posedge clock) if (if1.imem_read_enable) if1.imem_data <= mem_word(int'(if1.imem_address));

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    stall = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({if4.if_id_reg, if4.if_id_valid, if4.if_id_pc, if4.halted, if4.imem_read_enable} !== 42'd0) begin
      errors++; $display("FAIL reset_outputs got reg=%h vld=%b pc=%0d halt=%b ren=%b want all 0",
        if4.if_id_reg, if4.if_id_valid, if4.if_id_pc, if4.halted, if4.imem_read_enable);
    end
    checks++;
    if ({if8.imem_read_enable, if1.imem_read_enable} !== 2'b00) begin
      errors++; $display("FAIL reset_read_enable got %b%b want 00", if8.imem_read_enable, if1.imem_read_enable);
    end
    @(negedge clock) reset = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    checks++;
    if (if4.if_id_valid !== 1'b1 || if4.if_id_reg !== mem_word(0)) begin
      errors++; $display("FAIL reset_first_word got vld=%b reg=%h want 1 %h", if4.if_id_valid, if4.if_id_reg, mem_word(0));
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (if4.if_id_valid !== 1'b0 || if4.if_id_reg !== 32'd0) begin
      errors++; $display("FAIL reset_async got vld=%b reg=%h want 0 0", if4.if_id_valid, if4.if_id_reg);
    end
  endtask

  task automatic test_basic();
    logic [39:0] e;
    apply_reset();
    for (int i = 0; i < 4; i++) exp_q.push_back({8'(i), mem_word(i)});
    for (int ed = 1; ed <= 8; ed++) begin
      @(posedge clock); #1;
      checks++;
      if (if4.if_id_valid !== (ed >= 2 && ed <= 5)) begin
        errors++; $display("FAIL basic_valid edge %0d got %b want %b", ed, if4.if_id_valid, (ed >= 2 && ed <= 5));
      end
      checks++;
      if (if4.halted !== (ed >= 6)) begin
        errors++; $display("FAIL basic_halted edge %0d got %b want %b", ed, if4.halted, (ed >= 6));
      end
      if (if4.if_id_valid && !stall) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL basic_extra_word edge %0d got %h want none", ed, if4.if_id_reg);
        end else begin
          e = exp_q.pop_front();
          if ({if4.if_id_pc, if4.if_id_reg} !== e) begin
            errors++; $display("FAIL basic_word edge %0d got pc=%0d %h want pc=%0d %h", ed, if4.if_id_pc, if4.if_id_reg, e[39:32], e[31:0]);
          end
        end
      end else if (!if4.if_id_valid) begin
        checks++;
        if ({if4.if_id_pc, if4.if_id_reg} !== 40'd0) begin
          errors++; $display("FAIL basic_bubble edge %0d got pc=%0d %h want 0 0", ed, if4.if_id_pc, if4.if_id_reg);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL basic_missing got %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_stall_skid();
    logic [39:0] e;
    apply_reset();
    for (int i = 0; i < 4; i++) exp_q.push_back({8'(i), mem_word(i)});
    for (int ed = 1; ed <= 10; ed++) begin
      @(posedge clock); #1;
      if (stall) begin
        checks++;
        if (if4.imem_read_enable !== 1'b0) begin
          errors++; $display("FAIL skid_read_in_stall edge %0d got %b want 0", ed, if4.imem_read_enable);
        end
        checks++;
        if (if4.if_id_valid !== 1'b1 || if4.if_id_reg !== mem_word(0)) begin
          errors++; $display("FAIL skid_hold edge %0d got vld=%b %h want 1 %h", ed, if4.if_id_valid, if4.if_id_reg, mem_word(0));
        end
      end
      if (ed == 6 || ed == 7) begin
        checks++;
        if (if4.if_id_valid !== 1'b1 || if4.if_id_reg !== mem_word(ed - 5)) begin
          errors++; $display("FAIL skid_release edge %0d got vld=%b %h want 1 %h", ed, if4.if_id_valid, if4.if_id_reg, mem_word(ed - 5));
        end
      end
      if (if4.if_id_valid && !stall) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL skid_extra_word edge %0d got %h want none", ed, if4.if_id_reg);
        end else begin
          e = exp_q.pop_front();
          if ({if4.if_id_pc, if4.if_id_reg} !== e) begin
            errors++; $display("FAIL skid_word edge %0d got pc=%0d %h want pc=%0d %h", ed, if4.if_id_pc, if4.if_id_reg, e[39:32], e[31:0]);
          end
        end
      end
      @(negedge clock);
      stall = (ed >= 2 && ed <= 4);
    end
    checks++;
    if (exp_q.size() != 0 || if4.halted !== 1'b1) begin
      errors++; $display("FAIL skid_end got left=%0d halted=%b want 0 1", exp_q.size(), if4.halted);
    end
  endtask

  task automatic test_stall_toggle();
    logic [39:0] e;
    apply_reset();
    for (int i = 0; i < 8; i++) exp_q.push_back({8'(i), mem_word(i)});
    for (int ed = 1; ed <= 50; ed++) begin
      @(posedge clock); #1;
      if (stall) begin
        checks++;
        if (if8.imem_read_enable !== 1'b0) begin
          errors++; $display("FAIL toggle_read_in_stall edge %0d got %b want 0", ed, if8.imem_read_enable);
        end
      end
      if (if8.if_id_valid && !stall) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL toggle_extra_word edge %0d got %h want none", ed, if8.if_id_reg);
        end else begin
          e = exp_q.pop_front();
          if ({if8.if_id_pc, if8.if_id_reg} !== e) begin
            errors++; $display("FAIL toggle_word edge %0d got pc=%0d %h want pc=%0d %h", ed, if8.if_id_pc, if8.if_id_reg, e[39:32], e[31:0]);
          end
        end
      end
      @(negedge clock);
      stall = (ed <= 20) && (ed % 2 == 1);
    end
    checks++;
    if (exp_q.size() != 0 || if8.halted !== 1'b1) begin
      errors++; $display("FAIL toggle_end got left=%0d halted=%b want 0 1", exp_q.size(), if8.halted);
    end
  endtask

  task automatic test_stall_after_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    stall = 1'b1;
    for (int ed = 1; ed <= 4; ed++) begin
      @(posedge clock); #1;
      if (ed <= 2) begin
        checks++;
        if (if4.imem_read_enable !== 1'b0 || if4.if_id_reg !== 32'd0) begin
          errors++; $display("FAIL early_stall edge %0d got ren=%b reg=%h want 0 0", ed, if4.imem_read_enable, if4.if_id_reg);
        end
      end else if (ed == 3) begin
        checks++;
        if (if4.if_id_valid !== 1'b0 || if4.if_id_reg !== 32'd0) begin
          errors++; $display("FAIL early_bubble got vld=%b reg=%h want 0 0", if4.if_id_valid, if4.if_id_reg);
        end
      end else begin
        checks++;
        if (if4.if_id_valid !== 1'b1 || if4.if_id_reg !== mem_word(0) || if4.if_id_pc !== 8'd0) begin
          errors++; $display("FAIL early_first_word got vld=%b pc=%0d %h want 1 0 %h", if4.if_id_valid, if4.if_id_pc, if4.if_id_reg, mem_word(0));
        end
      end
      @(negedge clock);
      if (ed == 2) stall = 1'b0;
    end
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    @(posedge clock); @(posedge clock);
    @(negedge clock) stall = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (if4.if_id_reg !== mem_word(0)) begin
      errors++; $display("FAIL midrst_hold got %h want %h", if4.if_id_reg, mem_word(0));
    end
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({if4.if_id_reg, if4.if_id_valid, if4.if_id_pc, if4.halted, if4.imem_read_enable, if4.imem_address} !== 50'd0) begin
      errors++; $display("FAIL midrst_outputs got reg=%h vld=%b pc=%0d halt=%b ren=%b addr=%0d want all 0",
        if4.if_id_reg, if4.if_id_valid, if4.if_id_pc, if4.halted, if4.imem_read_enable, if4.imem_address);
    end
    @(negedge clock);
    reset = 1'b0;
    stall = 1'b0;
    #1;
    checks++;
    if (if4.imem_read_enable !== 1'b1 || if4.imem_address !== 8'd0) begin
      errors++; $display("FAIL midrst_restart got ren=%b addr=%0d want 1 0", if4.imem_read_enable, if4.imem_address);
    end
    for (int ed = 1; ed <= 3; ed++) begin
      @(posedge clock); #1;
      checks++;
      if (ed == 1 && if4.if_id_valid !== 1'b0) begin
        errors++; $display("FAIL midrst_edge1 got vld=%b want 0", if4.if_id_valid);
      end else if (ed > 1 && (if4.if_id_valid !== 1'b1 || if4.if_id_reg !== mem_word(ed - 2))) begin
        errors++; $display("FAIL midrst_word edge %0d got vld=%b %h want 1 %h", ed, if4.if_id_valid, if4.if_id_reg, mem_word(ed - 2));
      end
    end
  endtask

  task automatic test_depth_one();
    int nvalid = 0;
    apply_reset();
    #1;
    checks++;
    if (if1.imem_read_enable !== 1'b1) begin
      errors++; $display("FAIL d1_first_read got %b want 1", if1.imem_read_enable);
    end
    for (int ed = 1; ed <= 13; ed++) begin
      @(posedge clock); #1;
      if (if1.if_id_valid) nvalid++;
      if (ed == 2) begin
        checks++;
        if (if1.if_id_valid !== 1'b1 || if1.if_id_reg !== mem_word(0) || if1.halted !== 1'b0) begin
          errors++; $display("FAIL d1_word got vld=%b %h halt=%b want 1 %h 0", if1.if_id_valid, if1.if_id_reg, if1.halted, mem_word(0));
        end
      end else if (ed >= 3) begin
        checks++;
        if (if1.halted !== 1'b1 || if1.imem_read_enable !== 1'b0 || if1.if_id_reg !== 32'd0) begin
          errors++; $display("FAIL d1_halted edge %0d got halt=%b ren=%b reg=%h want 1 0 0", ed, if1.halted, if1.imem_read_enable, if1.if_id_reg);
        end
      end
    end
    checks++;
    if (nvalid != 1) begin
      errors++; $display("FAIL d1_count got %0d want 1", nvalid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall_skid();
    test_stall_toggle();
    test_stall_after_reset();
    test_reset_mid_stall();
    test_depth_one();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage: the producer side of the 32-bit `if_id_reg` word consumed by the decode stage. It walks a program counter through a synchronous-read instruction memory and presents one instruction per cycle. It honours the pipeline `stall` without losing or duplicating words, and emits all-zero no-ops (type `2'b00`) whenever it has no valid instruction. Fetch halts cleanly at the end of the program image.

## Interface
- `ADDR_WIDTH`, 8: instruction memory address width.
- `PROGRAM_DEPTH`, 256: number of valid words; must be ≤ 2^ADDR_WIDTH and ≥ 1.

Ports:
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `stall` in 1: pipeline stall; same signal the decode stage sees.
- `imem_address` out ADDR_WIDTH: read address, equal to `pc[ADDR_WIDTH-1:0]`.
- `imem_read_enable` out 1: combinational read strobe, `!reset && !stall && (pc < PROGRAM_DEPTH)`.
- `imem_data` in 32: read data, valid the cycle after a sampled read.
- `if_id_reg` out 32: instruction to decode; `32'd0` means no-op.
- `if_id_valid` out 1: `if_id_reg` holds a real fetched word.
- `if_id_pc` out ADDR_WIDTH: address of the word in `if_id_reg`; 0 when invalid.
- `halted` out 1: program exhausted and the last word has been delivered.

## Operation
State:
- `pc`: ADDR_WIDTH+1 bits, so it can reach PROGRAM_DEPTH.
- `inflight`, 1 bit, plus `inflight_pc`: a read was issued last cycle.
- Skid entry: `skid_valid`, `skid_data`, `skid_pc`.

Issue:
- When `imem_read_enable` is high, the memory samples `imem_address`.
- On that edge: `pc <= pc+1`, `inflight <= 1`, `inflight_pc <= pc`.
- Otherwise `inflight <= 0`.
- At most one read is in flight. No read is issued while `stall` is high.

Deliver, each edge, in priority order:
1. `stall` high and `inflight`: `imem_data` and `inflight_pc` go into skid; `skid_valid <= 1`. `if_id_*` hold.
2. `stall` high, no inflight: everything holds.
3. `stall` low and `skid_valid`: `if_id_reg <= skid_data`, `if_id_pc <= skid_pc`, `if_id_valid <= 1`, `skid_valid <= 0`. A new read may issue this same cycle.
4. `stall` low and `inflight`: `if_id_reg <= imem_data`, valid 1.
5. `stall` low, nothing available: bubble. `if_id_reg <= 0`, `if_id_valid <= 0`, `if_id_pc <= 0`.

Invariants:
- Skid and inflight can never both need storage while stalled, because no reads issue during stall. Overflow is therefore impossible.
- The skid entry is emptied before any in-flight data. Program order is preserved and no word is dropped or duplicated.

End of program:
- Once `pc == PROGRAM_DEPTH`, read enable stays low. `pc` never wraps.
- `halted` is registered. It goes to 1 on the edge where `pc == PROGRAM_DEPTH`, `!inflight`, `!skid_valid` and the last word has already left for `if_id_reg`.
- After that, unstalled cycles deliver no-ops. `halted` stays 1 until reset.

Reset (asynchronous, any time including mid-stall or with skid full):
- `pc`, `inflight`, `skid_valid`, `if_id_reg`, `if_id_valid`, `if_id_pc` and `halted` all go to 0.
- In-flight data is discarded.
- `imem_read_enable` is 0 while reset is high.

## Timing
- First edge after reset deassert with no stall: address 0 is sampled.
- Second edge: `if_id_reg = mem[0]`. Fetch latency is 2 edges; throughput is 1 word/cycle.
- Stall asserted for N cycles then released: at most one word sits in skid. The first unstalled edge presents it, and the next edge presents the following word, with no bubble.
- Stall only in the first cycle after reset: no read issued, no data returns, and the unstalled edge produces a bubble.
- PROGRAM_DEPTH = 1: `mem[0]` is delivered at edge 2; `halted` rises at edge 3.

## Test plan
- Memory holds `mem[i] = 32'h2000_0000 + i`, DEPTH 4, no stall. Required: `if_id_reg` shows 2000_0000 … 2000_0003 on edges 2–5 with `if_id_pc` 0–3, then 0 with valid 0. `halted` is 1 at edge 6.
- Stall high for 3 cycles starting the cycle after address 1 is sampled. Required: `if_id_reg` holds `mem[0]`; `mem[1]` is captured in skid. After release, `mem[1]` then `mem[2]` appear on consecutive edges with nothing skipped or repeated.
- Stall toggled every cycle for 20 cycles (DEPTH 8). Required: valid words appear in order 0..7, each exactly once; `imem_read_enable` is never high while stall is high.
- Stall high from reset deassert for 2 cycles. Required: no read is issued, `if_id_reg` stays 0, and the first valid word is `mem[0]` 2 edges after stall drops.
- Reset pulsed mid-stall with skid full. Required: all outputs are 0 immediately, asynchronously. After release, fetch restarts at address 0 and `mem[0]` appears 2 edges later.
- DEPTH 1 run. Required: exactly one valid word `mem[0]`, `halted` goes high, and 10 further cycles keep `imem_read_enable` 0 and `if_id_reg` 0.
